// File: rtl/rv32i_pkg.sv
// rv32i_pkg
// Shared definitions for the issue scheduler slice: the op-class enum and
// its decode function, the scheduler FSM state enum, and named op codes for
// the upper-immediate and jump instructions.
// No ports (package).
package rv32i_pkg;

  typedef enum logic [1:0] {
    CLS_ALU,
    CLS_LOAD,
    CLS_STORE,
    CLS_CTRL
  } op_class_t;

  typedef enum logic [0:0] {
    RUN,
    BR_WAIT
  } sched_state_t;

  localparam logic [4:0] OP_LUI   = 5'b11100;
  localparam logic [4:0] OP_AUIPC = 5'b11101;
  localparam logic [4:0] OP_JAL   = 5'b11110;
  localparam logic [4:0] OP_JALR  = 5'b11111;

  // Anything that is not a load, store or control op goes to the ALU,
  // including the unused 11011 slot.
  function automatic op_class_t op_class(input logic [4:0] op);
    op_class_t cls;
    cls = CLS_ALU;
    if (op[4:3] == 2'b10)
      cls = CLS_LOAD;
    else if (op == 5'b11000 || op == 5'b11001 || op == 5'b11010)
      cls = CLS_STORE;
    else if (op == 5'b01000 || op == 5'b01001 || op[4:2] == 3'b011 ||
             op == OP_JAL || op == OP_JALR)
      cls = CLS_CTRL;
    return cls;
  endfunction

  // Jumps are control ops but still write their link register; branches
  // and stores never write. Writes to x0 are discarded, so never tracked.
  function automatic logic op_writes_rd(input logic [4:0] op, input logic [4:0] rd);
    op_class_t cls;
    cls = op_class(op);
    return ((cls == CLS_LOAD) || (cls == CLS_ALU) || (op == OP_JAL) || (op == OP_JALR))
           && (rd != 5'd0);
  endfunction

endpackage

// File: rtl/rv32i_scoreboard.sv
// rv32i_scoreboard
// One busy bit per architectural register. A register is marked busy when
// an instruction that writes it issues and is released when its result is
// written back. x0 is never busy.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   set_en / set_idx     mark a register busy (issue)
//   clr_en / clr_idx     release a register (writeback)
//   mask_en / mask_idx   hide one busy bit from the hazard lookup only
//   rs1_idx/rs2_idx/rd_idx  lookup indices
//   rs1_busy/rs2_busy/rd_busy  lookup results
//   busy                 raw busy vector
module rv32i_scoreboard #(
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            set_en,
  input  logic [4:0]      set_idx,
  input  logic            clr_en,
  input  logic [4:0]      clr_idx,
  input  logic            mask_en,
  input  logic [4:0]      mask_idx,
  input  logic [4:0]      rs1_idx,
  input  logic [4:0]      rs2_idx,
  input  logic [4:0]      rd_idx,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            rd_busy,
  output logic [NREG-1:0] busy
);

  logic [NREG-1:0] busy_next;
  logic [NREG-1:0] visible;

  // The set is applied after the clear so that a register released and
  // re-claimed in the same cycle stays busy for its new producer.
  always_comb begin
    busy_next = busy;
    if (clr_en) busy_next[clr_idx] = 1'b0;
    if (set_en) busy_next[set_idx] = 1'b1;
    busy_next[0] = 1'b0;
  end

  // Busy vector storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_next;
  end

  // The mask lets a register being written back this cycle look free to
  // the hazard check without touching the stored vector.
  always_comb begin
    visible = busy;
    if (mask_en) visible[mask_idx] = 1'b0;
  end

  assign rs1_busy = visible[rs1_idx];
  assign rs2_busy = visible[rs2_idx];
  assign rd_busy  = visible[rd_idx];

endmodule

// File: rtl/rv32i_issue_sched.sv
// rv32i_issue_sched
// Issue scheduler between the RV32I decoder and the execute units. Holds a
// decoded instruction on RAW/WAW hazards, dispatches it to the ALU, LSU or
// branch unit, and arbitrates the single register-file write port between
// load results, a one-entry ALU skid buffer and ALU results.
// Optional feature: define ISSUE_WB_BYPASS_EN to let an instruction issue
// in the same cycle its producer writes back (needs a write-through RF).
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   dec_valid/dec_ready/dec_op/dec_rd/dec_rs1/dec_rs2/dec_use_rs1/dec_use_rs2
//                                    decoder handshake and instruction fields
//   alu_issue, br_issue              single-cycle dispatch pulses
//   lsu_issue/lsu_ready              load/store valid/ready pair
//   br_done                          branch unit resolved the control op
//   alu_res_*, lsu_res_*             results from the execute units
//   rf_we/rf_waddr/rf_wdata          register-file write port
//   busy                             scoreboard vector (debug)
module rv32i_issue_sched
  import rv32i_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            dec_valid,
  output logic            dec_ready,
  input  logic [4:0]      dec_op,
  input  logic [4:0]      dec_rd,
  input  logic [4:0]      dec_rs1,
  input  logic [4:0]      dec_rs2,
  input  logic            dec_use_rs1,
  input  logic            dec_use_rs2,
  output logic            alu_issue,
  output logic            lsu_issue,
  input  logic            lsu_ready,
  output logic            br_issue,
  input  logic            br_done,
  input  logic            alu_res_valid,
  input  logic [4:0]      alu_res_rd,
  input  logic [XLEN-1:0] alu_res_data,
  input  logic            lsu_res_valid,
  input  logic [4:0]      lsu_res_rd,
  input  logic [XLEN-1:0] lsu_res_data,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic [NREG-1:0] busy
);

  op_class_t    cls;
  sched_state_t state, state_next;
  logic         writes_rd, hazard, alu_ok, can_issue, is_lsu_op;
  logic         rs1_busy, rs2_busy, rd_busy, mask_en;
  logic            skid_valid;
  logic [4:0]      skid_rd;
  logic [XLEN-1:0] skid_data;

`ifdef ISSUE_WB_BYPASS_EN
  assign mask_en = rf_we;
`else
  assign mask_en = 1'b0;
`endif

  rv32i_scoreboard #(.NREG(NREG)) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (dec_ready & writes_rd),
    .set_idx  (dec_rd),
    .clr_en   (rf_we),
    .clr_idx  (rf_waddr),
    .mask_en  (mask_en),
    .mask_idx (rf_waddr),
    .rs1_idx  (dec_rs1),
    .rs2_idx  (dec_rs2),
    .rd_idx   (dec_rd),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .rd_busy  (rd_busy),
    .busy     (busy)
  );

  assign cls       = op_class(dec_op);
  assign writes_rd = op_writes_rd(dec_op, dec_rd);
  assign is_lsu_op = (cls == CLS_LOAD) || (cls == CLS_STORE);
  assign hazard    = (dec_use_rs1 & rs1_busy) | (dec_use_rs2 & rs2_busy) | (writes_rd & rd_busy);

  // An ALU op may only issue if its result, arriving next cycle, is sure to
  // find room: either the write port or the (empty) skid buffer.
  assign alu_ok    = !skid_valid && !(alu_res_valid && lsu_res_valid);
  assign can_issue = dec_valid && (state == RUN) && !hazard;

  // Control ops travel through the ALU too (link value), so they share its
  // back-pressure condition.
  assign dec_ready = can_issue && (is_lsu_op ? lsu_ready : alu_ok);
  assign alu_issue = dec_ready && !is_lsu_op;
  assign br_issue  = dec_ready && (cls == CLS_CTRL);
  assign lsu_issue = can_issue && is_lsu_op;

  // Issue stops after a control op until the branch unit resolves it.
  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (br_issue) state_next = BR_WAIT;
      BR_WAIT: if (br_done)  state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_next;
  end

  // Write port priority: load result, then the buffered ALU result, then a
  // fresh ALU result. Loads have no buffer, so they must always win.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (lsu_res_valid) begin
      rf_we    = 1'b1;
      rf_waddr = lsu_res_rd;
      rf_wdata = lsu_res_data;
    end else if (skid_valid) begin
      rf_we    = 1'b1;
      rf_waddr = skid_rd;
      rf_wdata = skid_data;
    end else if (alu_res_valid) begin
      rf_we    = 1'b1;
      rf_waddr = alu_res_rd;
      rf_wdata = alu_res_data;
    end
  end

  // Skid buffer: captures an ALU result that lost arbitration and empties
  // on the first cycle without a load result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_valid <= 1'b0;
      skid_rd    <= '0;
      skid_data  <= '0;
    end else if (alu_res_valid && (lsu_res_valid || skid_valid)) begin
      skid_valid <= 1'b1;
      skid_rd    <= alu_res_rd;
      skid_data  <= alu_res_data;
    end else if (skid_valid && !lsu_res_valid) begin
      skid_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rv32i_issue_sched.sv
// tb_rv32i_issue_sched
// Self-checking bench for rv32i_issue_sched. Models a one-cycle ALU that
// returns a result for every alu_issue, keeps a queue of expected
// register-file writes in arbitration order, and walks a table of op codes
// plus hand-written hazard, collision, branch and reset sequences.
module tb_rv32i_issue_sched;

  logic        clk, rst_n;
  logic        dec_valid, dec_ready;
  logic [4:0]  dec_op, dec_rd, dec_rs1, dec_rs2;
  logic        dec_use_rs1, dec_use_rs2;
  logic        alu_issue, lsu_issue, lsu_ready, br_issue, br_done;
  logic        alu_res_valid, lsu_res_valid;
  logic [4:0]  alu_res_rd, lsu_res_rd;
  logic [31:0] alu_res_data, lsu_res_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] busy;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  typedef struct {
    logic [4:0] op;
    logic       lsuRdy;
    logic [3:0] exp;
    string      name;
  } vec_t;

  wb_t   expQ[$];
  vec_t  vecs[17];
  int    total = 0;
  int    bad = 0;
  logic [31:0] aluDataNext = 32'hD0D0_0000;

  rv32i_issue_sched dut (
    .clk(clk), .rst_n(rst_n),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_op(dec_op),
    .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2),
    .alu_issue(alu_issue), .lsu_issue(lsu_issue), .lsu_ready(lsu_ready),
    .br_issue(br_issue), .br_done(br_done),
    .alu_res_valid(alu_res_valid), .alu_res_rd(alu_res_rd), .alu_res_data(alu_res_data),
    .lsu_res_valid(lsu_res_valid), .lsu_res_rd(lsu_res_rd), .lsu_res_data(lsu_res_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .busy(busy)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Dispatch outputs packed as {dec_ready, alu_issue, lsu_issue, br_issue}.
  function automatic logic [31:0] issueVec();
    return {28'b0, dec_ready, alu_issue, lsu_issue, br_issue};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h need=%h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [4:0] op, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2);
    dec_valid   = v;
    dec_op      = op;
    dec_rd      = rd;
    dec_rs1     = rs1;
    dec_rs2     = rs2;
    dec_use_rs1 = u1;
    dec_use_rs2 = u2;
    #2;
  endtask

  task automatic idle();
    dec_valid = 1'b0;
  endtask

  // Load result for this cycle; it outranks an ALU result driven in the
  // same cycle, so its expected write goes in front of that one.
  task automatic driveLsu(input logic [4:0] rd, input logic [31:0] data);
    wb_t e;
    e.rd = rd;
    e.data = data;
    lsu_res_valid = 1'b1;
    lsu_res_rd    = rd;
    lsu_res_data  = data;
    if (alu_res_valid) expQ.insert(expQ.size() - 1, e);
    else               expQ.push_back(e);
  endtask

  // Checks any write seen this cycle against the queue, then advances one
  // clock and plays the ALU returning the result of an op issued this cycle.
  task automatic nextCycle();
    logic       pend;
    logic [4:0] prd;
    wb_t        e;
    @(negedge clk);
    if (rf_we) begin
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL wb_unexpected got x%0d=%h need no write", rf_waddr, rf_wdata);
      end else begin
        e = expQ.pop_front();
        checkOutput("wb_addr", {27'b0, rf_waddr}, {27'b0, e.rd});
        checkOutput("wb_data", rf_wdata, e.data);
      end
    end
    pend = alu_issue;
    prd  = dec_rd;
    @(posedge clk);
    #1;
    lsu_res_valid = 1'b0;
    br_done       = 1'b0;
    alu_res_valid = pend & rst_n;
    alu_res_rd    = prd;
    alu_res_data  = aluDataNext;
    if (alu_res_valid) begin
      e.rd = prd;
      e.data = aluDataNext;
      expQ.push_back(e);
    end
  endtask

  initial begin
    vecs[0]  = '{op:5'b00000, lsuRdy:1'b1, exp:4'b1100, name:"cls_00000"};
    vecs[1]  = '{op:5'b01010, lsuRdy:1'b1, exp:4'b1100, name:"cls_01010"};
    vecs[2]  = '{op:5'b01011, lsuRdy:1'b1, exp:4'b1100, name:"cls_01011"};
    vecs[3]  = '{op:5'b11100, lsuRdy:1'b1, exp:4'b1100, name:"cls_lui"};
    vecs[4]  = '{op:5'b11101, lsuRdy:1'b1, exp:4'b1100, name:"cls_auipc"};
    vecs[5]  = '{op:5'b11011, lsuRdy:1'b1, exp:4'b1100, name:"cls_11011"};
    vecs[6]  = '{op:5'b10000, lsuRdy:1'b1, exp:4'b1010, name:"cls_load_rdy"};
    vecs[7]  = '{op:5'b10111, lsuRdy:1'b0, exp:4'b0010, name:"cls_load_norrdy"};
    vecs[8]  = '{op:5'b11000, lsuRdy:1'b1, exp:4'b1010, name:"cls_store_rdy"};
    vecs[9]  = '{op:5'b11010, lsuRdy:1'b0, exp:4'b0010, name:"cls_store_nordy"};
    vecs[10] = '{op:5'b01000, lsuRdy:1'b1, exp:4'b1101, name:"cls_01000"};
    vecs[11] = '{op:5'b01001, lsuRdy:1'b1, exp:4'b1101, name:"cls_01001"};
    vecs[12] = '{op:5'b01100, lsuRdy:1'b1, exp:4'b1101, name:"cls_01100"};
    vecs[13] = '{op:5'b01111, lsuRdy:1'b1, exp:4'b1101, name:"cls_01111"};
    vecs[14] = '{op:5'b11110, lsuRdy:1'b1, exp:4'b1101, name:"cls_jal"};
    vecs[15] = '{op:5'b11111, lsuRdy:1'b1, exp:4'b1101, name:"cls_jalr"};
    vecs[16] = '{op:5'b00111, lsuRdy:1'b0, exp:4'b1100, name:"cls_alu_nordy"};

    rst_n = 1'b0;
    dec_valid = 1'b0; dec_op = '0; dec_rd = '0; dec_rs1 = '0; dec_rs2 = '0;
    dec_use_rs1 = 1'b0; dec_use_rs2 = 1'b0;
    lsu_ready = 1'b1; br_done = 1'b0;
    alu_res_valid = 1'b0; alu_res_rd = '0; alu_res_data = '0;
    lsu_res_valid = 1'b0; lsu_res_rd = '0; lsu_res_data = '0;
    #12;
    checkOutput("reset_issue", issueVec(), 32'h0);
    checkOutput("reset_wport", {26'b0, rf_we, rf_waddr}, 32'h0);
    checkOutput("reset_wdata", rf_wdata, 32'h0);
    checkOutput("reset_busy", busy, 32'h0);
    rst_n = 1'b1;
    nextCycle();

    // Op-class decode with an empty scoreboard; nothing is left valid at
    // the clock edge, so no state changes between vectors.
    for (int i = 0; i < 17; i++) begin
      lsu_ready = vecs[i].lsuRdy;
      applyStimulus(1'b1, vecs[i].op, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0);
      checkOutput(vecs[i].name, issueVec(), {28'b0, vecs[i].exp});
      idle();
      nextCycle();
    end
    lsu_ready = 1'b1;

    // ADDI x5 then ADD x6,x5,x5.
    applyStimulus(1'b1, 5'b00000, 5'd5, 5'd0, 5'd0, 1'b1, 1'b0);
    checkOutput("chain_prod", issueVec(), 32'b1100);
    nextCycle();
    checkOutput("chain_busy", busy, 32'h0000_0020);
    applyStimulus(1'b1, 5'b00000, 5'd6, 5'd5, 5'd5, 1'b1, 1'b1);
`ifdef ISSUE_WB_BYPASS_EN
    checkOutput("chain_n1", issueVec(), 32'b1100);
`else
    checkOutput("chain_n1", issueVec(), 32'b0000);
    nextCycle();
    applyStimulus(1'b1, 5'b00000, 5'd6, 5'd5, 5'd5, 1'b1, 1'b1);
    checkOutput("chain_n2", issueVec(), 32'b1100);
`endif
    nextCycle();
    idle();
    nextCycle();
    checkOutput("chain_clear", busy, 32'h0);

    // Load x7 returning after 4 cycles, ADD x8,x7,x0 waiting on it.
    applyStimulus(1'b1, 5'b10000, 5'd7, 5'd1, 5'd0, 1'b1, 1'b0);
    checkOutput("load_acc", issueVec(), 32'b1010);
    nextCycle();
    checkOutput("load_busy", busy, 32'h0000_0080);
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b1, 5'b00000, 5'd8, 5'd7, 5'd0, 1'b1, 1'b1);
      checkOutput("load_stall", issueVec(), 32'b0000);
      nextCycle();
    end
    driveLsu(5'd7, 32'h1234_5678);
    applyStimulus(1'b1, 5'b00000, 5'd8, 5'd7, 5'd0, 1'b1, 1'b1);
`ifdef ISSUE_WB_BYPASS_EN
    checkOutput("load_wb_cycle", issueVec(), 32'b1100);
`else
    checkOutput("load_wb_cycle", issueVec(), 32'b0000);
    nextCycle();
    applyStimulus(1'b1, 5'b00000, 5'd8, 5'd7, 5'd0, 1'b1, 1'b1);
    checkOutput("load_after", issueVec(), 32'b1100);
`endif
    nextCycle();
    idle();
    nextCycle();

    // Load x3 and ALU x4 results in the same cycle.
    applyStimulus(1'b1, 5'b00000, 5'd4, 5'd0, 5'd0, 1'b1, 1'b0);
    checkOutput("coll_prod", issueVec(), 32'b1100);
    aluDataNext = 32'h0000_5555;
    nextCycle();
    driveLsu(5'd3, 32'h0000_AAAA);
    applyStimulus(1'b1, 5'b00000, 5'd9, 5'd0, 5'd0, 1'b1, 1'b0);
    checkOutput("coll_block_both", issueVec(), 32'b0000);
    nextCycle();
    applyStimulus(1'b1, 5'b00000, 5'd9, 5'd0, 5'd0, 1'b1, 1'b0);
    checkOutput("coll_block_skid", issueVec(), 32'b0000);
    nextCycle();
    applyStimulus(1'b1, 5'b00000, 5'd9, 5'd0, 5'd0, 1'b1, 1'b0);
    checkOutput("coll_resume", issueVec(), 32'b1100);
    aluDataNext = 32'hD0D0_0000;
    nextCycle();
    idle();
    nextCycle();

    // BEQ waits five cycles for br_done, then a pending ADDI issues.
    applyStimulus(1'b1, 5'b01100, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1);
    checkOutput("beq_acc", issueVec(), 32'b1101);
    nextCycle();
    for (int i = 1; i <= 5; i++) begin
      if (i == 5) br_done = 1'b1;
      applyStimulus(1'b1, 5'b00000, 5'd10, 5'd0, 5'd0, 1'b1, 1'b0);
      checkOutput("beq_wait", issueVec(), 32'b0000);
      nextCycle();
    end
    applyStimulus(1'b1, 5'b00000, 5'd10, 5'd0, 5'd0, 1'b1, 1'b0);
    checkOutput("beq_resume", issueVec(), 32'b1100);
    nextCycle();
    idle();
    nextCycle();

    // ADDI x0 never marks x0, so a reader of x0 goes straight through.
    applyStimulus(1'b1, 5'b00000, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    checkOutput("x0_acc", issueVec(), 32'b1100);
    nextCycle();
    checkOutput("x0_busy", busy, 32'h0);
    applyStimulus(1'b1, 5'b00000, 5'd11, 5'd0, 5'd0, 1'b1, 1'b1);
    checkOutput("x0_read", issueVec(), 32'b1100);
    nextCycle();
    idle();
    nextCycle();

    // JAL marks its link register and also waits for br_done.
    applyStimulus(1'b1, 5'b11110, 5'd13, 5'd0, 5'd0, 1'b0, 1'b0);
    checkOutput("jal_acc", issueVec(), 32'b1101);
    nextCycle();
    checkOutput("jal_busy", busy, 32'h0000_2000);
    br_done = 1'b1;
    applyStimulus(1'b1, 5'b00000, 5'd14, 5'd0, 5'd0, 1'b1, 1'b0);
    checkOutput("jal_wait", issueVec(), 32'b0000);
    nextCycle();
    applyStimulus(1'b1, 5'b00000, 5'd14, 5'd0, 5'd0, 1'b1, 1'b0);
    checkOutput("jal_resume", issueVec(), 32'b1100);
    nextCycle();
    idle();
    nextCycle();

    // Reset while x5/x7 are busy and a branch is outstanding.
    applyStimulus(1'b1, 5'b10000, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0);
    checkOutput("rst_ld5", issueVec(), 32'b1010);
    nextCycle();
    applyStimulus(1'b1, 5'b10000, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0);
    checkOutput("rst_ld7", issueVec(), 32'b1010);
    nextCycle();
    applyStimulus(1'b1, 5'b01100, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    checkOutput("rst_beq", issueVec(), 32'b1101);
    nextCycle();
    checkOutput("rst_pre_busy", busy, 32'h0000_00A0);
    applyStimulus(1'b1, 5'b00000, 5'd12, 5'd0, 5'd0, 1'b0, 1'b0);
    checkOutput("rst_pre_wait", issueVec(), 32'b0000);
    idle();
    rst_n = 1'b0;
    alu_res_valid = 1'b0;
    expQ.delete();
    #1;
    checkOutput("rst_mid_busy", busy, 32'h0);
    checkOutput("rst_mid_issue", issueVec(), 32'h0);
    checkOutput("rst_mid_wport", {26'b0, rf_we, rf_waddr}, 32'h0);
    checkOutput("rst_mid_wdata", rf_wdata, 32'h0);
    nextCycle();
    rst_n = 1'b1;
    applyStimulus(1'b1, 5'b00000, 5'd5, 5'd5, 5'd7, 1'b1, 1'b1);
    checkOutput("rst_after", issueVec(), 32'b1100);
    nextCycle();
    idle();
    nextCycle();
    nextCycle();

    checkOutput("wb_drain", expQ.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
